// File: rtl/tile_pkg.sv
// Shared constants, state encoding and saturating arithmetic for the tile hit judge.
// The optional combo score bonus is enabled by defining TILE_COMBO_BONUS_EN.
package tile_pkg;

  localparam int NUM_LANES  = 4;
  localparam int TILE_SIZE  = 75;
  localparam int HIT_Y_MIN  = 330;
  localparam int BOTTOM_Y   = 479;
  localparam int MAX_MISSES = 5;
  localparam int SPEED_STEP = 10;

  // Lane i's key sits in byte i: D, F, J, K.
  localparam logic [NUM_LANES-1:0][7:0] LANE_KEYS = {8'h0E, 8'h0D, 8'h09, 8'h07};
  localparam logic [7:0] KEY_START = 8'h2C;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/tile_hit_judge_if.sv
// Bundle between the tile movers / keyboard / HUD side and the hit judge.
// The master side drives keys and tile positions; the slave side is the judge.
interface tile_hit_judge_if;
  logic [7:0]  keycode;
  logic [3:0]  new_note;
  logic [9:0]  tile_y0;
  logic [9:0]  tile_y1;
  logic [9:0]  tile_y2;
  logic [9:0]  tile_y3;
  logic [3:0]  kill;
  logic [3:0]  speed;
  logic [15:0] score;
  logic [3:0]  misses;
  logic [7:0]  combo;
  logic [1:0]  state_o;

  modport master (
    output keycode, new_note, tile_y0, tile_y1, tile_y2, tile_y3,
    input  kill, speed, score, misses, combo, state_o
  );

  modport slave (
    input  keycode, new_note, tile_y0, tile_y1, tile_y2, tile_y3,
    output kill, speed, score, misses, combo, state_o
  );
endinterface

// File: rtl/tile_lane_judge.sv
// Combinational judgement of one lane: hit, miss count (fall-through plus wrong press)
// and the kill request that the top registers.
module tile_lane_judge
  import tile_pkg::*;
(
  input  logic       live,
  input  logic [9:0] tile_y,
  input  logic       new_note,
  input  logic       press,
  output logic       hit,
  output logic [1:0] miss,
  output logic       kill
);

  logic [10:0] bot;
  logic        inwin;
  logic        fell;
  logic        wrong;

  // Bottom edge is formed at 11 bits so a tile near the screen bottom cannot wrap.
  assign bot   = {1'b0, tile_y} + 11'(TILE_SIZE);
  assign inwin = live && (bot >= 11'(HIT_Y_MIN)) && (bot < 11'(BOTTOM_Y));
  assign fell  = live && (bot >= 11'(BOTTOM_Y));
  assign wrong = press && !inwin;

  assign hit  = press && inwin;
  assign miss = {1'b0, fell} + {1'b0, wrong};
  // A fresh spawn on this lane wins: the mover must keep its new tile.
  assign kill = (hit || fell) && !new_note;

endmodule

// File: rtl/tile_hit_judge.sv
// Game-state keeper: press detect, IDLE/PLAY/OVER FSM, per-lane live flags and counters.
// Define TILE_COMBO_BONUS_EN to enable the combo counter and combo score bonus.
module tile_hit_judge
  import tile_pkg::*;
(
  input  logic             frame_clk,
  input  logic             Reset,
  tile_hit_judge_if.slave  bus
);

  state_e                          state;
  logic [7:0]                      prev_key;
  logic [NUM_LANES-1:0]            live;
  logic [NUM_LANES-1:0]            kill_q;
  logic [3:0]                      speed;
  logic [3:0]                      step;
  logic [15:0]                     score;
  logic [3:0]                      misses;

  logic                            press;
  logic                            start_press;
  logic [NUM_LANES-1:0]            lane_press;
  logic [NUM_LANES-1:0][9:0]       tile_y;
  logic [NUM_LANES-1:0]            hit;
  logic [NUM_LANES-1:0][1:0]       miss_cnt;
  logic [NUM_LANES-1:0]            kill_req;
  logic [NUM_LANES-1:0]            live_next;
  logic [2:0]                      miss_inc;
  logic [4:0]                      miss_sum;
  logic [3:0]                      misses_sat;
  logic                            any_hit;
  logic                            any_miss;
  logic [15:0]                     score_inc;
  logic [15:0]                     score_sum;
  logic                            count_adv;

  assign press       = (bus.keycode != prev_key) && (bus.keycode != 8'h00);
  assign start_press = press && (bus.keycode == KEY_START);
  assign tile_y      = {bus.tile_y3, bus.tile_y2, bus.tile_y1, bus.tile_y0};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_press[i] = press && (bus.keycode == LANE_KEYS[i]);

    tile_lane_judge u_lane (
      .live     (live[i]),
      .tile_y   (tile_y[i]),
      .new_note (bus.new_note[i]),
      .press    (lane_press[i]),
      .hit      (hit[i]),
      .miss     (miss_cnt[i]),
      .kill     (kill_req[i])
    );
  end

`ifdef TILE_COMBO_BONUS_EN
  logic [7:0]  combo;
  logic [15:0] hits;
  logic [1:0]  bonus;

  assign bonus     = (combo[7:3] > 5'd3) ? 2'd3 : combo[4:3];
  assign score_inc = 16'd1 + {14'd0, bonus};
  assign count_adv = any_hit && (hits != 16'hFFFF);
  assign bus.combo = combo;
`else
  assign score_inc = 16'd1;
  assign count_adv = any_hit && (score != 16'hFFFF);
  assign bus.combo = 8'd0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    miss_inc  = 3'd0;
    live_next = bus.new_note | live;
    for (int i = 0; i < NUM_LANES; i++) begin
      miss_inc = miss_inc + {1'b0, miss_cnt[i]};
      if ((hit[i] || (miss_cnt[i] != 2'd0)) && !bus.new_note[i]) live_next[i] = 1'b0;
    end
  end

  assign any_hit    = |hit;
  assign any_miss   = (miss_inc != 3'd0);
  assign miss_sum   = {1'b0, misses} + {2'b00, miss_inc};
  assign misses_sat = (miss_sum >= 5'(MAX_MISSES)) ? 4'(MAX_MISSES) : miss_sum[3:0];
  assign score_sum  = sat_add16(score, score_inc);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state    <= IDLE;
      prev_key <= 8'h00;
      live     <= '0;
      kill_q   <= '0;
      speed    <= 4'd0;
      step     <= 4'd0;
      score    <= 16'd0;
      misses   <= 4'd0;
`ifdef TILE_COMBO_BONUS_EN
      combo    <= 8'd0;
      hits     <= 16'd0;
`endif
    end else begin
      prev_key <= bus.keycode;
      kill_q   <= '0;
      unique case (state)
        IDLE: begin
          if (start_press) begin
            state  <= PLAY;
            live   <= '0;
            speed  <= 4'd0;
            step   <= 4'd0;
            score  <= 16'd0;
            misses <= 4'd0;
`ifdef TILE_COMBO_BONUS_EN
            combo  <= 8'd0;
            hits   <= 16'd0;
`endif
          end
        end
        PLAY: begin
          live   <= live_next;
          kill_q <= kill_req;
          misses <= misses_sat;
          if (misses_sat == 4'(MAX_MISSES)) state <= OVER;
          if (any_hit) score <= score_sum;
          // Speed tracks multiples of SPEED_STEP via a wrap-around step counter.
          if (count_adv) begin
            if (step == 4'(SPEED_STEP - 1)) begin
              step <= 4'd0;
              if (speed != 4'hF) speed <= speed + 4'd1;
            end else begin
              step <= step + 4'd1;
            end
          end
`ifdef TILE_COMBO_BONUS_EN
          if (any_hit) hits <= sat_add16(hits, 16'd1);
          if (any_miss)                    combo <= 8'd0;
          else if (any_hit && combo != 8'hFF) combo <= combo + 8'd1;
`endif
        end
        OVER: begin
          if (start_press) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.kill    = kill_q;
  assign bus.speed   = speed;
  assign bus.score   = score;
  assign bus.misses  = misses;
  assign bus.state_o = state;

endmodule

// File: tb/tb_tile_hit_judge.sv
// Self-checking bench for tile_hit_judge: vector table plus hand-written game sequences,
// with expected outputs queued at drive time and popped after each frame edge.
module tb_tile_hit_judge;
  import tile_pkg::*;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;

  tile_hit_judge_if bus ();

  tile_hit_judge dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic              rst;
    logic [7:0]        key;
    logic [3:0]        nn;
    logic [3:0][9:0]   ty;
    logic [3:0]        kill;
    logic [3:0]        speed;
    logic [15:0]       score;
    logic [3:0]        misses;
    logic [7:0]        combo;
    logic [1:0]        state;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  int exp_sc, exp_cb, exp_hits, exp_spd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [7:0] key, input logic [3:0] nn,
                              input int y0, input int y1, input int y2, input int y3,
                              input logic [3:0] kl, input int spd, input int sc,
                              input int ms, input int cb, input int st);
    vec_t v;
    v.rst    = rst;
    v.key    = key;
    v.nn     = nn;
    v.ty[0]  = 10'(y0);
    v.ty[1]  = 10'(y1);
    v.ty[2]  = 10'(y2);
    v.ty[3]  = 10'(y3);
    v.kill   = kl;
    v.speed  = 4'(spd);
    v.score  = 16'(sc);
    v.misses = 4'(ms);
`ifdef TILE_COMBO_BONUS_EN
    v.combo  = 8'(cb);
`else
    v.combo  = 8'd0 & 8'(cb);
`endif
    v.state  = 2'(st);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    Reset        = v.rst;
    bus.keycode  = v.key;
    bus.new_note = v.nn;
    bus.tile_y0  = v.ty[0];
    bus.tile_y1  = v.ty[1];
    bus.tile_y2  = v.ty[2];
    bus.tile_y3  = v.ty[3];
    sb.push_back(v);
    @(posedge frame_clk);
    #1;
    e = sb.pop_front();
    check($sformatf("step%0d kill", step_no),   bus.kill,    e.kill);
    check($sformatf("step%0d speed", step_no),  bus.speed,   e.speed);
    check($sformatf("step%0d score", step_no),  bus.score,   e.score);
    check($sformatf("step%0d misses", step_no), bus.misses,  e.misses);
    check($sformatf("step%0d combo", step_no),  bus.combo,   e.combo);
    check($sformatf("step%0d state", step_no),  bus.state_o, e.state);
    step_no++;
  endtask

  // Spawn a lane-0 tile in the window, then hit it; expectations follow the scoring rules.
  task automatic run_hits(input int n);
    int add;
    for (int k = 0; k < n; k++) begin
      apply(mk(0, 8'h00, 4'b0001, 300, 0, 0, 0, 4'b0000, exp_spd, exp_sc, 0, exp_cb, 1));
`ifdef TILE_COMBO_BONUS_EN
      add = 1 + (((exp_cb >> 3) > 3) ? 3 : (exp_cb >> 3));
`else
      add = 1;
`endif
      exp_sc   = exp_sc + add;
      exp_cb   = exp_cb + 1;
      exp_hits = exp_hits + 1;
`ifdef TILE_COMBO_BONUS_EN
      exp_spd  = exp_hits / SPEED_STEP;
`else
      exp_spd  = exp_sc / SPEED_STEP;
`endif
      apply(mk(0, 8'h07, 4'b0000, 300, 0, 0, 0, 4'b0001, exp_spd, exp_sc, 0, exp_cb, 1));
    end
  endtask

  task automatic start_game();
    apply(mk(0, KEY_START, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    exp_sc = 0; exp_cb = 0; exp_hits = 0; exp_spd = 0;
  endtask

  initial begin
    bus.keycode = 8'h00; bus.new_note = 4'h0;
    bus.tile_y0 = 10'd0; bus.tile_y1 = 10'd0; bus.tile_y2 = 10'd0; bus.tile_y3 = 10'd0;

    //            rst key    nn       y0   y1   y2   y3   kill     spd sc ms cb st
    tbl.push_back(mk(1, 8'h00, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h09, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h2C, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0010,   0, 300,   0,   0, 4'b0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h09, 4'b0000,   0, 300,   0,   0, 4'b0010, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 8'h09, 4'b0000,   0, 300,   0,   0, 4'b0000, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0100,   0,   0, 400,   0, 4'b0000, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0000,   0,   0, 404,   0, 4'b0100, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 8'h0D, 4'b0000,   0,   0, 404,   0, 4'b0000, 0, 1, 2, 0, 1));
    tbl.push_back(mk(0, 8'h0D, 4'b0000,   0,   0, 404,   0, 4'b0000, 0, 1, 2, 0, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0001, 100,   0,   0,   0, 4'b0000, 0, 1, 2, 0, 1));
    tbl.push_back(mk(0, 8'h07, 4'b0000, 100,   0,   0,   0, 4'b0000, 0, 1, 3, 0, 1));
    tbl.push_back(mk(0, 8'h00, 4'b1010,   0, 300,   0, 200, 4'b0000, 0, 1, 3, 0, 1));
    tbl.push_back(mk(0, 8'h09, 4'b0000,   0, 300,   0, 420, 4'b1010, 0, 2, 4, 0, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 2, 4, 0, 1));
    tbl.push_back(mk(0, 8'h0E, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 2, 5, 0, 2));
    tbl.push_back(mk(0, 8'h00, 4'b1111, 404, 404, 404, 404, 4'b0000, 0, 2, 5, 0, 2));
    tbl.push_back(mk(0, 8'h09, 4'b0000, 404, 404, 404, 404, 4'b0000, 0, 2, 5, 0, 2));
    tbl.push_back(mk(0, 8'h2C, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 2, 5, 0, 0));
    tbl.push_back(mk(0, 8'h00, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 2, 5, 0, 0));
    tbl.push_back(mk(0, 8'h2C, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0011, 254, 255,   0,   0, 4'b0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h07, 4'b0000, 254, 255,   0,   0, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h09, 4'b0000, 254, 255,   0,   0, 4'b0010, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0100,   0,   0, 403,   0, 4'b0000, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 4'b0000,   0,   0, 403,   0, 4'b0000, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 8'h0D, 4'b0000,   0,   0, 403,   0, 4'b0100, 0, 2, 1, 2, 1));
    tbl.push_back(mk(1, 8'h00, 4'b0000,   0,   0,   0,   0, 4'b0000, 0, 0, 0, 0, 0));

    @(negedge frame_clk);
    foreach (tbl[i]) apply(tbl[i]);

    // Reset in the middle of a game holding score 7.
    start_game();
    run_hits(7);
    apply(mk(1, 8'h00, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    // Ten consecutive hits raise speed to 1 (combo bonus kicks in at combo 8 when enabled).
    start_game();
    run_hits(10);

    // Three wrong presses, then three simultaneous fall-throughs saturate misses at 5.
    for (int k = 1; k <= 3; k++) begin
      apply(mk(0, 8'h0E, 4'b0000, 0, 0, 0, 0, 4'b0000, exp_spd, exp_sc, k, 0, 1));
      apply(mk(0, 8'h00, 4'b0000, 0, 0, 0, 0, 4'b0000, exp_spd, exp_sc, k, 0, 1));
    end
    apply(mk(0, 8'h00, 4'b0111,   0,   0,   0, 0, 4'b0000, exp_spd, exp_sc, 3, 0, 1));
    apply(mk(0, 8'h00, 4'b0000, 404, 404, 404, 0, 4'b0111, exp_spd, exp_sc, 5, 0, 2));
    apply(mk(0, 8'h2C, 4'b0000,   0,   0,   0, 0, 4'b0000, exp_spd, exp_sc, 5, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_hit_judge.md
Name: tile_hit_judge

Overview:
- Judges player key presses against the four falling tile lanes and keeps game state.
- Sits downstream of the four per-lane tile movers: consumes their Y positions and produces their `kill` pulses.
- Also feeds `speed[3:0]` back to all movers, and score/miss counts to the HUD/text renderer.
- A small IDLE/PLAY/OVER FSM gates all judging.

Parameters:
- TILE_SIZE, 75, tile height in pixels (matches mover size output)
- HIT_Y_MIN, 330, a tile is hittable once tile_y+TILE_SIZE >= HIT_Y_MIN
- BOTTOM_Y, 479, a live tile with tile_y+TILE_SIZE >= BOTTOM_Y is a miss
- MAX_MISSES, 5, miss count that ends the game
- SPEED_STEP, 10, hits per speed increment

Ports:
- frame_clk  in  1  single clock, one edge per video frame
- Reset  in  1  synchronous, active-high
- keycode  in  8  current USB keycode, 0 = no key
- new_note  in  4  per-lane spawn pulse, same signal that drives each mover's newNote
- tile_y0..tile_y3  in  10 each  lane tile Y position from movers
- kill  out  4  one-cycle pulse per lane to mover kill input
- speed  out  4  speed to all movers
- score  out  16  hit score, saturating
- misses  out  4  miss count, saturating at MAX_MISSES
- combo  out  8  current hit streak (see optional feature)
- state_o  out  2  00 IDLE, 01 PLAY, 10 OVER

Behaviour:
- Reset (any state, mid-game included): state IDLE; kill=0, speed=0, score=0, misses=0, combo=0, live[3:0]=0, prev_key=0.
- Lane keys are 0x07 (D), 0x09 (F), 0x0D (J), 0x0E (K) for lanes 0..3; start key is 0x2C (space).
- Press detect: press = (keycode != prev_key) && keycode != 0; prev_key <= keycode every cycle. At most one press per cycle.
- FSM:
  - IDLE -> PLAY on a space press; this also clears score, misses, combo and speed.
  - PLAY -> OVER in the cycle misses reaches MAX_MISSES.
  - OVER -> IDLE on a space press.
  - Outside PLAY: new_note is ignored, kill=0, counters are held.
- Per-lane live flag (PLAY only):
  - new_note[i] sets live[i].
  - A hit or a miss clears live[i].
  - new_note[i] in the same cycle as a hit/miss on lane i: new_note wins, live stays 1 and no kill is issued for that lane.
- Width rule: bot_i = {1'b0,tile_y_i} + TILE_SIZE, computed at 11 bits (no wrap).
- Classification per lane:
  - inwin_i = live_i && bot_i >= HIT_Y_MIN && bot_i < BOTTOM_Y.
  - fell_i = live_i && bot_i >= BOTTOM_Y.
- Hit: press of lane i key with inwin_i.
  - Registered output kill[i]=1 on the next edge (latency 1), for exactly one cycle.
  - score += 1 (no wrap, saturates at 0xFFFF); combo += 1 (saturates at 255).
- Wrong press: lane key pressed with !inwin_i (no live tile, or tile above window) is a miss. misses += 1, combo <= 0, no kill.
- Fall-through: each fell_i is a miss.
  - misses += popcount of all fell plus any wrong press in the same cycle, saturating at MAX_MISSES.
  - live_i cleared, kill[i]=1 for one cycle so the mover parks the tile; combo <= 0.
- Hit and fell on different lanes in the same cycle: both processed; combo ends at 0 (miss wins).
- Speed: increments by 1 each time score crosses a multiple of SPEED_STEP, saturating at 15.
- Non-lane, non-space keycodes are ignored.

Optional Feature:
- Macro TILE_COMBO_BONUS_EN.
- Defined: hit adds 1 + min(combo>>3, 3) to score, using combo before the increment.
- Undefined: hit adds 1, and the combo output is tied to 0 (counter not synthesized).
- The speed rule uses the hit count, not score, when the macro is defined; a separate 16-bit hit counter exists only under the macro.

Decomposition:
- Package tile_pkg: NUM_LANES=4, lane keycode array, KEY_START=8'h2C, state enum (IDLE/PLAY/OVER), saturating-add function.
- Sub-module tile_lane_judge, instantiated 4 times:
  - Inputs: live flag, tile_y, new_note, lane press.
  - Outputs: hit, miss, kill.
- Top keeps the FSM, press detect and counters.

Test Plan:
- Reset mid-PLAY with score=7 -> next edge state=IDLE, score=0, misses=0, kill=0.
- Space, new_note[1], tile_y1=300 (bot 375), keycode 0x09 pressed -> kill=4'b0010 one cycle later, score=1, combo=1.
- Lane 2 live, tile_y2=404 (bot 479) -> kill[2] pulse, misses=1, combo=0, live[2]=0; holding 0x0D afterwards gives no further press.
- Keycode 0x07 pressed with lane 0 tile at y=100 (bot 175) -> misses+1, no kill, score unchanged.
- Five misses -> state=OVER; subsequent new_note and keys ignored; space -> IDLE.
- Ten consecutive hits -> speed=1 after the 10th. With TILE_COMBO_BONUS_EN, the 9th hit (combo 8) adds 2 to score.
